// File: rtl/vpu_ovi_pkg.sv
// Shared types for the core-side OVI issue scheduler: ring entry state,
// scoreboard id and the registered issue payload.
package vpu_ovi_pkg;

  typedef logic [4:0] ovi_sb_id_t;

  typedef enum logic [1:0] {
    ENT_FREE   = 2'd0,
    ENT_ISSUED = 2'd1,
    ENT_SENIOR = 2'd2,
    ENT_KILLED = 2'd3
  } ent_state_t;

  typedef struct packed {
    logic [31:0] inst;
    ovi_sb_id_t  sb_id;
    logic [63:0] scalar;
    logic [39:0] vcsr;
    logic        lmulb2;
  } ovi_issue_t;

  typedef struct packed {
    ent_state_t state;
    ovi_sb_id_t sb_id;
  } ring_entry_t;

endpackage

// File: rtl/vpu_ovi_issue_ctrl_if.sv
// Core request, OVI issue/dispatch/completion and retire signals of the issue scheduler.
// master = scheduler side, slave = core/VPU environment side.
interface vpu_ovi_issue_ctrl_if;
  import vpu_ovi_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  ovi_sb_id_t  req_sb_id;
  logic [63:0] req_scalar_opnd;
  logic [39:0] req_vcsr;
  logic        req_vcsr_lmulb2;

  logic [31:0] issue_inst;
  ovi_sb_id_t  issue_sb_id;
  logic [63:0] issue_scalar_opnd;
  logic [39:0] issue_vcsr;
  logic        issue_vcsr_lmulb2;
  logic        issue_valid;
  logic        issue_credit;

  logic        commit_valid;
  logic        commit_kill;
  ovi_sb_id_t  dispatch_sb_id;
  logic        dispatch_next_senior;
  logic        dispatch_kill;

  logic        completed_valid;
  ovi_sb_id_t  completed_sb_id;
  logic        retire_valid;
  ovi_sb_id_t  retire_sb_id;

  modport master (
    input  req_valid, req_inst, req_sb_id, req_scalar_opnd, req_vcsr, req_vcsr_lmulb2,
    input  issue_credit, commit_valid, commit_kill, completed_valid, completed_sb_id,
    output req_ready,
    output issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2, issue_valid,
    output dispatch_sb_id, dispatch_next_senior, dispatch_kill,
    output retire_valid, retire_sb_id
  );

  modport slave (
    output req_valid, req_inst, req_sb_id, req_scalar_opnd, req_vcsr, req_vcsr_lmulb2,
    output issue_credit, commit_valid, commit_kill, completed_valid, completed_sb_id,
    input  req_ready,
    input  issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2, issue_valid,
    input  dispatch_sb_id, dispatch_next_senior, dispatch_kill,
    input  retire_valid, retire_sb_id
  );

endinterface

// File: rtl/vpu_ovi_issue_ctrl.sv
// Core-side OVI issue scheduler: credit-gated issue, in-order tracking ring,
// commit/squash to dispatch pulses, in-order retirement with protocol checks.
//
// entry state | meaning
// ENT_FREE    | slot unused
// ENT_ISSUED  | sent to VPU, awaiting core commit decision
// ENT_SENIOR  | committed, awaiting completion
// ENT_KILLED  | squashed, freed silently when it reaches head
module vpu_ovi_issue_ctrl
  import vpu_ovi_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vpu_ovi_issue_ctrl_if.master bus,
  output logic                 commit_err,
  output logic                 cmpl_err,
  output logic                 credit_err,
  output logic                 idle
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [CW-1:0] credits;
  logic [PW-1:0] head, disp, tail;
  ring_entry_t   ring [DEPTH];
  ovi_issue_t    issue_q;
  logic          issue_valid_q;
  ovi_sb_id_t    dispatch_sb_id_q;
  logic          dispatch_next_senior_q;
  logic          dispatch_kill_q;
  logic          retire_valid_q;
  ovi_sb_id_t    retire_sb_id_q;

  logic [AW-1:0] head_idx, disp_idx, tail_idx;
  logic          full, empty, sb_hit, accept, do_commit;
  logic          retire_kill, cmpl_match;

  assign head_idx = head[AW-1:0];
  assign disp_idx = disp[AW-1:0];
  assign tail_idx = tail[AW-1:0];

  assign full  = (head[AW] != tail[AW]) && (head_idx == tail_idx);
  assign empty = (head == tail);

  // A scoreboard id may only be in flight once.
  always_comb begin
    sb_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ring[i].state != ENT_FREE && ring[i].sb_id == bus.req_sb_id) sb_hit = 1'b1;
    end
  end

  assign bus.req_ready = (credits != '0) && !full && !sb_hit;
  assign accept        = bus.req_valid && bus.req_ready;
  assign do_commit     = bus.commit_valid && (disp != tail);
  assign retire_kill   = (ring[head_idx].state == ENT_KILLED);
  assign cmpl_match    = bus.completed_valid && (ring[head_idx].state == ENT_SENIOR) &&
                         (ring[head_idx].sb_id == bus.completed_sb_id);
  assign idle          = empty && (credits == CRED_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits                <= CRED_MAX;
      head                   <= '0;
      disp                   <= '0;
      tail                   <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '{state: ENT_FREE, sb_id: '0};
      issue_q                <= '0;
      issue_valid_q          <= 1'b0;
      dispatch_sb_id_q       <= '0;
      dispatch_next_senior_q <= 1'b0;
      dispatch_kill_q        <= 1'b0;
      retire_valid_q         <= 1'b0;
      retire_sb_id_q         <= '0;
      commit_err             <= 1'b0;
      cmpl_err               <= 1'b0;
      credit_err             <= 1'b0;
    end else begin
      issue_valid_q <= accept;
      if (accept) begin
        issue_q        <= '{inst:   bus.req_inst,     sb_id:  bus.req_sb_id,
                            scalar: bus.req_scalar_opnd, vcsr: bus.req_vcsr,
                            lmulb2: bus.req_vcsr_lmulb2};
        ring[tail_idx] <= '{state: ENT_ISSUED, sb_id: bus.req_sb_id};
        tail           <= tail + 1'b1;
      end

      dispatch_next_senior_q <= do_commit && !bus.commit_kill;
      dispatch_kill_q        <= do_commit && bus.commit_kill;
      commit_err             <= bus.commit_valid && (disp == tail);
      if (do_commit) begin
        ring[disp_idx].state <= bus.commit_kill ? ENT_KILLED : ENT_SENIOR;
        dispatch_sb_id_q     <= ring[disp_idx].sb_id;
        disp                 <= disp + 1'b1;
      end

      // Head entry is never the dispatch or allocation slot when it retires.
      retire_valid_q <= cmpl_match;
      cmpl_err       <= bus.completed_valid && !cmpl_match;
      if (retire_kill || cmpl_match) begin
        ring[head_idx].state <= ENT_FREE;
        head                 <= head + 1'b1;
      end
      if (cmpl_match) retire_sb_id_q <= ring[head_idx].sb_id;

      credit_err <= bus.issue_credit && !accept && (credits == CRED_MAX);
      case ({accept, bus.issue_credit})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits != CRED_MAX) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign bus.issue_valid          = issue_valid_q;
  assign bus.issue_inst           = issue_q.inst;
  assign bus.issue_sb_id          = issue_q.sb_id;
  assign bus.issue_scalar_opnd    = issue_q.scalar;
  assign bus.issue_vcsr           = issue_q.vcsr;
  assign bus.issue_vcsr_lmulb2    = issue_q.lmulb2;
  assign bus.dispatch_sb_id       = dispatch_sb_id_q;
  assign bus.dispatch_next_senior = dispatch_next_senior_q;
  assign bus.dispatch_kill        = dispatch_kill_q;
  assign bus.retire_valid         = retire_valid_q;
  assign bus.retire_sb_id         = retire_sb_id_q;

endmodule

// File: doc/vpu_ovi_issue_ctrl.md
# vpu_ovi_issue_ctrl

Core-side scheduler for the `Vpu` OVI port. It accepts vector instructions from the core pipeline and drives the OVI issue channel under credit flow control. It tracks every in-flight instruction in an in-order ring, turns core commit/squash decisions into `dispatch_next_senior`/`dispatch_kill` pulses, and retires entries on `completed_valid`, flagging protocol violations.

## Interface
- `CREDITS`, default 8: initial and maximum VPU issue credits.
- `DEPTH`, default 8: tracking-ring entries, power of two.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core offers an instruction.
- `req_ready` out 1: accept; transfer when valid && ready.
- `req_inst`, `req_sb_id`, `req_scalar_opnd`, `req_vcsr`, `req_vcsr_lmulb2` in 32/5/64/40/1: instruction payload.
- `issue_inst`, `issue_sb_id`, `issue_scalar_opnd`, `issue_vcsr`, `issue_vcsr_lmulb2`, `issue_valid` out 32/5/64/40/1/1: OVI issue channel.
- `issue_credit` in 1: credit return, one credit per cycle high.
- `commit_valid` in 1: core resolves the oldest undispatched instruction.
- `commit_kill` in 1: with `commit_valid`, 1 = squash, 0 = senior.
- `dispatch_sb_id`, `dispatch_next_senior`, `dispatch_kill` out 5/1/1: OVI dispatch channel.
- `completed_valid`, `completed_sb_id` in 1/5: OVI completion (other completion fields go straight to the core).
- `retire_valid`, `retire_sb_id` out 1/5: entry retired.
- `commit_err`, `cmpl_err`, `credit_err` out 1 each: one-cycle protocol-violation pulses.
- `idle` out 1: ring empty and credits == `CREDITS`.

## Operation
- Credit counter: width clog2(`CREDITS`+1); reset = `CREDITS`. Decrement on accept, increment on `issue_credit`; both in the same cycle leave it unchanged. `issue_credit` at `CREDITS` with no accept: counter saturates and `credit_err` pulses.
- `req_ready` = credits > 0 && ring not full && no live entry holds `req_sb_id` (combinational, no dependence on `req_valid`).
- Ring pointers head, disp, tail, each log2(`DEPTH`)+1 bits with wrap bit. Full when pointers are equal except the wrap bit.
- Per-entry state: FREE, ISSUED, SENIOR, KILLED, plus stored `sb_id`.
  - Accept: entry[tail] ← ISSUED; tail++.
  - Commit with disp ≠ tail: entry[disp] ← SENIOR or KILLED; dispatch pulse carries that entry's `sb_id`; disp++.
  - Commit with disp == tail: `commit_err` pulses; no dispatch pulse.
- Head retirement, at most one entry per cycle:
  - KILLED at head: → FREE; head++; `retire_valid` is not raised.
  - SENIOR at head with `completed_valid` and matching `sb_id`: → FREE; head++; `retire_valid` pulses.
- `completed_valid` that does not match a SENIOR head entry: `cmpl_err` pulses; state unchanged.
- Same-cycle accept, commit, completion and credit return are all legal. The entry allocated in a cycle is visible to commit from the next cycle.
- Reset mid-operation: all entries FREE, pointers 0, credits `CREDITS`. In-flight instructions are forgotten.

## Timing
- Reset values:
  - `req_ready`: 1.
  - `idle`: 1.
  - All other outputs: 0 (including issue and dispatch payloads).
- Accept in cycle N → `issue_valid` and payload registered, high exactly in N+1.
- `commit_valid` in N → `dispatch_*` in N+1, single-cycle pulse.
- Matching completion in N → `retire_valid`/`retire_sb_id` in N+1.
- Error outputs are registered and appear one cycle after the offending input.
- Back-to-back accepts sustain one per cycle while credits last.

## Structure
- Package `vpu_ovi_pkg`: entry-state enum, `ovi_sb_id_t` (5 bits), OVI issue-payload struct (inst, sb_id, scalar, vcsr, lmulb2).
- Single module. The `sb_id` CAM compare over the ring is an inline loop; no sub-module.

## Test plan
- `CREDITS`=2, 3 back-to-back requests, no `issue_credit` → two `issue_valid` pulses, `req_ready`=0 on the third. One `issue_credit` → third issues next cycle.
- Issue sb 3, 4; commit senior, then kill → `dispatch_next_senior` with sb_id 3, `dispatch_kill` with sb_id 4. Complete sb 3 → `retire_sb_id` = 3, then ring empty and `idle`=1 once credits return.
- Completion for sb 7 while head is ISSUED sb 3 → `cmpl_err` pulse, no retirement.
- Request sb 5 while sb 5 is live → `req_ready`=0 until sb 5 retires.
- `commit_valid` with empty ring → `commit_err`, no dispatch. `issue_credit` at full credits → `credit_err`, counter stays 2.
- Fill all 8 entries with tail wrap, assert `reset_n` low mid-stream → outputs at reset values immediately, credits = `CREDITS` after release.
